// File: rtl/keypad_hex_entry.sv
// Keypad scanner and hex-digit entry: scans a 4x4 active-low matrix, debounces one key at a time, shifts accepted digits into a 32-bit value.
// Latency: a key is accepted DEBOUNCE_CNT row samples after first detection, plus 2 synchroniser cycles; the pulse lasts one cycle.
// Backpressure: none; the scan free-runs and oDigitValid is a fire-and-forget pulse.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   iCol[3:0]      keypad columns, active-low, asynchronous (synchronised internally)
//   iClear         synchronous clear of oValue
//   oRow[3:0]      row drive, active-low, one-hot-low
//   oValue[31:0]   entered hex value, newest digit in [3:0]
//   oDigit[3:0]    code of last accepted key
//   oDigitValid    one-cycle pulse per accepted key
//
// Build option: define KEYPAD_DEBOUNCE_EN to require DEBOUNCE_CNT stable samples
// on press and release. Without it a key is accepted on first detection and
// released on the first all-high sample; the debounce counter is not built.

module keypad_hex_entry #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  iCol,
    input  logic        iClear,
    output logic [3:0]  oRow,
    output logic [31:0] oValue,
    output logic [3:0]  oDigit,
    output logic        oDigitValid
);

    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [1:0]        row, row_nx;
    logic [3:0]        code, code_nx;
    logic [3:0]        col_meta, col_sync;
    logic [SLOT_W-1:0] slot_cnt;
    logic              slot_end;
    logic              any_low;
    logic [1:0]        low_col;

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DEB_W-1:0] DEB_TARGET = DEB_W'(DEBOUNCE_CNT);
    logic [DEB_W-1:0] deb_cnt, deb_nx, deb_inc;
    assign deb_inc = deb_cnt + 1'b1;
`endif

    assign slot_end    = (slot_cnt == SLOT_LAST);
    assign oRow        = ~(4'b0001 << row);
    assign oDigitValid = (state == PRESSED);

    // Lowest-indexed low column wins when several keys share the driven row.
    always_comb begin
        any_low = ~&col_sync;
        low_col = 2'd0;
        if (!col_sync[0])      low_col = 2'd0;
        else if (!col_sync[1]) low_col = 2'd1;
        else if (!col_sync[2]) low_col = 2'd2;
        else if (!col_sync[3]) low_col = 2'd3;
    end

    // Next-state logic. The row index only advances when the FSM returns to
    // (or stays in) SCAN; while a key is being tracked the row is frozen.
    always_comb begin
        state_nx = state;
        row_nx   = row;
        code_nx  = code;
`ifdef KEYPAD_DEBOUNCE_EN
        deb_nx   = deb_cnt;
`endif
        case (state)
            SCAN: begin
                if (slot_end) begin
                    if (any_low) begin
                        code_nx  = {row, low_col};
`ifdef KEYPAD_DEBOUNCE_EN
                        deb_nx   = '0;
                        state_nx = DEBOUNCE;
`else
                        state_nx = PRESSED;
`endif
                    end else begin
                        row_nx = row + 2'd1;
                    end
                end
            end
`ifdef KEYPAD_DEBOUNCE_EN
            DEBOUNCE: begin
                if (slot_end) begin
                    if (any_low && (low_col == code[1:0])) begin
                        deb_nx = deb_inc;
                        if (deb_inc == DEB_TARGET) state_nx = PRESSED;
                    end else begin
                        state_nx = SCAN;
                        row_nx   = row + 2'd1;
                    end
                end
            end
`endif
            PRESSED: begin
                state_nx = RELEASE;
`ifdef KEYPAD_DEBOUNCE_EN
                deb_nx   = '0;
`endif
            end
            RELEASE: begin
                if (slot_end) begin
`ifdef KEYPAD_DEBOUNCE_EN
                    if (!any_low) begin
                        deb_nx = deb_inc;
                        if (deb_inc == DEB_TARGET) begin
                            state_nx = SCAN;
                            row_nx   = row + 2'd1;
                        end
                    end else begin
                        deb_nx = '0;
                    end
`else
                    if (!any_low) begin
                        state_nx = SCAN;
                        row_nx   = row + 2'd1;
                    end
`endif
                end
            end
            default: state_nx = SCAN;
        endcase
    end

    // FSM and scan registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SCAN;
            row      <= 2'd0;
            code     <= 4'h0;
            col_meta <= 4'hF;
            col_sync <= 4'hF;
            slot_cnt <= '0;
`ifdef KEYPAD_DEBOUNCE_EN
            deb_cnt  <= '0;
`endif
        end else begin
            state    <= state_nx;
            row      <= row_nx;
            code     <= code_nx;
            col_meta <= iCol;
            col_sync <= col_meta;
            slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
`ifdef KEYPAD_DEBOUNCE_EN
            deb_cnt  <= deb_nx;
`endif
        end
    end

    // Output registers. oDigit is loaded on entry to PRESSED so it is valid
    // alongside the pulse; oValue shifts on the edge that leaves PRESSED.
    always_ff @(posedge clk) begin
        if (rst) begin
            oDigit <= 4'h0;
            oValue <= 32'h0;
        end else begin
            if (state_nx == PRESSED) oDigit <= code_nx;
            if (state == PRESSED)
                oValue <= iClear ? {28'h0, code} : {oValue[27:0], code};
            else if (iClear)
                oValue <= 32'h0;
        end
    end

endmodule
